// File: rtl/event_indicator_bank.sv
// Multi-channel event-to-LED stretcher: each channel holds its LED for a programmable window
// after an event, with optional retrigger and blink, plus a saturating event counter.
module event_indicator_bank #(
    parameter int CH          = 3,
    parameter int HOLD_W      = 26,
    parameter int HOLD_CYCLES = 33554432,
    parameter int BLINK_BIT   = 22,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       evt,
    input  logic [CH-1:0]       retrig_en,
    input  logic [CH-1:0]       blink_en,
    input  logic                clear,
    output logic [CH-1:0]       active,
    output logic [CH-1:0]       led,
    output logic [CH*CNT_W-1:0] event_cnt,
    output logic [CH-1:0]       cnt_sat
);

    localparam logic [HOLD_W-1:0] TIMER_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        state_t            state, state_nx;
        logic [HOLD_W-1:0] timer, timer_nx;
        logic              act_q, led_q, sat_q;
        logic [CNT_W-1:0]  cnt_q, cnt_inc;

        assign cnt_inc = cnt_q + CNT_W'(1);

        // An event in the last hold cycle always reloads so the window stays gapless.
        always_comb begin
            state_nx = state;
            timer_nx = timer;
            case (state)
                IDLE: begin
                    if (evt[g]) begin
                        state_nx = HOLD;
                        timer_nx = '0;
                    end
                end
                HOLD: begin
                    if (timer == TIMER_LAST) begin
                        timer_nx = '0;
                        if (!evt[g]) state_nx = IDLE;
                    end else if (evt[g] && retrig_en[g]) begin
                        timer_nx = '0;
                    end else begin
                        timer_nx = timer + HOLD_W'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    timer_nx = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= IDLE;
                timer <= '0;
                act_q <= 1'b0;
                led_q <= 1'b0;
                cnt_q <= '0;
                sat_q <= 1'b0;
            end else begin
                state <= state_nx;
                timer <= timer_nx;
                act_q <= (state_nx == HOLD);
                led_q <= (state_nx == HOLD) && !(blink_en[g] && timer_nx[BLINK_BIT]);
                if (clear) begin
                    cnt_q <= '0;
                    sat_q <= 1'b0;
                end else if (evt[g] && (cnt_q != '1)) begin
                    cnt_q <= cnt_inc;
                    if (cnt_inc == '1) sat_q <= 1'b1;
                end
            end
        end

        assign active[g]                     = act_q;
        assign led[g]                        = led_q;
        assign cnt_sat[g]                    = sat_q;
        assign event_cnt[g*CNT_W +: CNT_W]   = cnt_q;
    end

endmodule

// File: doc/event_indicator_bank.md
Name: event_indicator_bank

Overview:
- Parametrised, multi-channel successor to the single-purpose click/cheat LED stretchers used on board-level debug tops.
- Each channel turns short event pulses (mouse click, cheat trigger, card-play, network packet, ...) into a visible LED hold window.
- Per-channel runtime modes: retrigger and blink.
- Each channel keeps a saturating event counter for seven-segment or debug readout.
- Sits between interface blocks and board LEDs/display muxes on FPGA test tops.

Parameters:
- CH, 3: number of independent event channels.
- HOLD_W, 26: width of each channel's hold timer.
- HOLD_CYCLES, 33554432: LED hold length in clk cycles; legal range 2..2**HOLD_W.
- BLINK_BIT, 22: hold-timer bit that gates the LED in blink mode; must be < HOLD_W.
- CNT_W, 8: width of each channel's event counter.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- event  in  CH  per-channel event input, sampled every posedge; each high cycle is one event.
- retrig_en  in  CH  per channel: 1 = an event during hold restarts the window.
- blink_en  in  CH  per channel: 1 = LED blinks while the channel is active.
- clear  in  1  synchronous clear of all event counters and saturation flags.
- active  out  CH  per-channel hold window flag.
- led  out  CH  per-channel LED drive.
- event_cnt  out  CH*CNT_W  packed saturating counters; channel i occupies bits [i*CNT_W +: CNT_W].
- cnt_sat  out  CH  sticky flag per channel: counter has saturated.

Behaviour:
- Reset: rst is sampled at posedge. Next cycle, every state bit is cleared: active, led, event_cnt, cnt_sat, all timers. Events present while rst is high are ignored.
- Per-channel FSM, two states:
  - IDLE: active=0, timer=0.
  - HOLD: active=1, timer counts 0..HOLD_CYCLES-1.
- IDLE -> HOLD: event=1 at edge t. Then active=1 from cycle t+1, with timer=0.
- HOLD timing: timer increments by 1 per cycle. A lone event produces active high for exactly HOLD_CYCLES cycles, t+1..t+HOLD_CYCLES.
- HOLD -> IDLE: timer==HOLD_CYCLES-1 and event=0.
- Event in HOLD with timer < HOLD_CYCLES-1:
  - retrig_en=1: timer reloads to 0 next cycle, so the window ends HOLD_CYCLES cycles after this event.
  - retrig_en=0: timer is unaffected; the event is still counted.
- Event in the final hold cycle (timer==HOLD_CYCLES-1): timer reloads to 0 regardless of retrig_en. The window continues gapless; active never drops.
- retrig_en and blink_en are sampled every cycle. Changes take effect on the next evaluation; no latching.
- LED output:
  - blink_en=0: led = active.
  - blink_en=1: led = active & ~timer[BLINK_BIT].
  - LED is high in the first 2**BLINK_BIT cycles of each window, then toggles every 2**BLINK_BIT cycles.
  - A retrigger restarts the phase.
  - led and active are registered outputs; no combinational path from event.
- Counter:
  - Increments by 1 on each cycle with event=1, in any state.
  - Saturates at 2**CNT_W-1 and never wraps.
  - cnt_sat sets on the cycle the counter reaches max and stays set until clear or rst.
- clear: next cycle event_cnt=0 and cnt_sat=0 for all channels. clear has priority over a same-cycle event: that event is not counted but still triggers or retriggers the hold. Timers are unaffected by clear.
- Channels are fully independent. Simultaneous events on several channels are all handled in the same cycle.
- Width rules:
  - Timer compare is against HOLD_CYCLES-1 at HOLD_W bits.
  - HOLD_CYCLES=2**HOLD_W is legal (timer uses its full range).
  - Counter compare is against the all-ones value at CNT_W bits.

Test Plan (CH=3, HOLD_CYCLES=8, HOLD_W=4, BLINK_BIT=1, CNT_W=4):
- Single 1-cycle pulse on event[0] at edge t, modes 0 -> active[0] and led[0] high during cycles t+1..t+8, low at t+9; event_cnt[3:0]=1; other channels stay 0.
- retrig_en[1]=1, pulses on event[1] at t and t+5 -> active[1] high t+1..t+13. Repeat with retrig_en[1]=0 -> high t+1..t+8; count=2.
- retrig_en[0]=0, pulse at t and at t+8 (final hold cycle) -> active[0] continuously high t+1..t+16; no low gap.
- blink_en[2]=1, single pulse -> led[2] over t+1..t+8 = 1,1,0,0,1,1,0,0; active[2] all 1.
- Counter and clear on event[0]:
  - 20 single-cycle pulses -> event_cnt[3:0]=15, cnt_sat[0]=1.
  - clear -> 0 and 0.
  - clear asserted with a pulse in the same cycle -> count stays 0, active[0] still asserts next cycle.
- rst asserted mid-hold (timer=3), with an event present during rst -> next cycle all outputs 0. After rst deasserts, no activity until a new event.
